// File: rtl/serial_add_arbiter.sv
// Two-requester round-robin arbiter in front of a bit-serial adder.
// One operation takes WIDTH+2 cycles: grant, WIDTH add steps (last one lands the result), then a done cycle.
module serial_add_arbiter #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req0,
   input  logic             req1,
   input  logic [WIDTH-1:0] a0,
   input  logic [WIDTH-1:0] b0,
   input  logic [WIDTH-1:0] a1,
   input  logic [WIDTH-1:0] b1,
   output logic             gnt0,
   output logic             gnt1,
   output logic             busy,
   output logic             done,
   output logic             done_id,
   output logic [WIDTH-1:0] out,
   output logic             cout
);

   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic [WIDTH-1:0] out_q, out_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             carry_q, carry_d;
   logic             cout_q, cout_d;
   logic             last_id_q, last_id_d;
   logic             done_id_q, done_id_d;
   logic             gnt0_q, gnt0_d;
   logic             gnt1_q, gnt1_d;
   logic             done_q, done_d;
   logic             win;
   logic             s_bit;
   logic             c_next;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         a_q       <= '0;
         b_q       <= '0;
         sum_q     <= '0;
         out_q     <= '0;
         cnt_q     <= '0;
         carry_q   <= 1'b0;
         cout_q    <= 1'b0;
         last_id_q <= 1'b1;
         done_id_q <= 1'b0;
         gnt0_q    <= 1'b0;
         gnt1_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         a_q       <= a_d;
         b_q       <= b_d;
         sum_q     <= sum_d;
         out_q     <= out_d;
         cnt_q     <= cnt_d;
         carry_q   <= carry_d;
         cout_q    <= cout_d;
         last_id_q <= last_id_d;
         done_id_q <= done_id_d;
         gnt0_q    <= gnt0_d;
         gnt1_q    <= gnt1_d;
         done_q    <= done_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      a_d       = a_q;
      b_d       = b_q;
      sum_d     = sum_q;
      out_d     = out_q;
      cnt_d     = cnt_q;
      carry_d   = carry_q;
      cout_d    = cout_q;
      last_id_d = last_id_q;
      done_id_d = done_id_q;
      gnt0_d    = 1'b0;
      gnt1_d    = 1'b0;
      done_d    = 1'b0;
      // On contention the requester not served last wins; otherwise the lone requester.
      win       = (req0 && req1) ? ~last_id_q : req1;
      s_bit     = a_q[0] ^ b_q[0] ^ carry_q;
      c_next    = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);

      unique case (state_q)
         IDLE: begin
            if (req0 || req1) begin
               a_d       = win ? a1 : a0;
               b_d       = win ? b1 : b0;
               carry_d   = 1'b0;
               cnt_d     = '0;
               last_id_d = win;
               done_id_d = win;
               gnt0_d    = ~win;
               gnt1_d    = win;
               state_d   = ADD;
            end
         end
         ADD: begin
            a_d     = a_q >> 1;
            b_d     = b_q >> 1;
            sum_d   = {s_bit, sum_q[WIDTH-1:1]};
            carry_d = c_next;
            cnt_d   = cnt_q + 1'b1;
            // The final step publishes the sum including the bit computed this cycle.
            if (cnt_q == LAST_CNT) begin
               out_d   = {s_bit, sum_q[WIDTH-1:1]};
               cout_d  = c_next;
               done_d  = 1'b1;
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign gnt0    = gnt0_q;
   assign gnt1    = gnt1_q;
   assign busy    = (state_q != IDLE);
   assign done    = done_q;
   assign done_id = done_id_q;
   assign out     = out_q;
   assign cout    = cout_q;

endmodule

// File: tb/tb_serial_add_arbiter.sv
// Self-checking bench for serial_add_arbiter: directed vector table, corner sequences and random ops.
module tb_serial_add_arbiter;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         req0 = 1'b0, req1 = 1'b0;
   logic [W-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
   logic         gnt0, gnt1, busy, done, done_id, cout;
   logic [W-1:0] out;

   serial_add_arbiter #(.WIDTH(W)) dut (
      .clk(clk), .reset(reset), .req0(req0), .req1(req1),
      .a0(a0), .b0(b0), .a1(a1), .b1(b1),
      .gnt0(gnt0), .gnt1(gnt1), .busy(busy), .done(done),
      .done_id(done_id), .out(out), .cout(cout)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   int done_count = 0;
   int gnt1_count = 0;
   logic busy_prev = 1'b0;
   logic gnt0_prev = 1'b0, gnt1_prev = 1'b0;
   logic [W-1:0] prev_out = '0;
   logic         prev_cout = 1'b0;

   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Protocol monitor: grants exclusive, one cycle wide, never right after a busy cycle.
   always @(negedge clk) begin
      if (!reset) begin
         check("gnt_exclusive", {31'd0, gnt0 & gnt1}, 32'd0);
         check("gnt_after_busy", {31'd0, (gnt0 | gnt1) & busy_prev}, 32'd0);
         check("gnt_width", {31'd0, (gnt0 & gnt0_prev) | (gnt1 & gnt1_prev)}, 32'd0);
         if (done) done_count++;
         if (gnt1) gnt1_count++;
      end
      busy_prev = busy;
      gnt0_prev = gnt0;
      gnt1_prev = gnt1;
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic wait_gnt(input logic id, output int waited, output bit seen);
      waited = 0;
      seen = 0;
      while (!seen && waited < 20) begin
         @(negedge clk);
         waited++;
         if (id ? gnt1 : gnt0) seen = 1;
      end
   endtask

   // Runs one operation from IDLE and checks grant, result timing, result value and hold.
   task automatic run_op(input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] eo, input logic ec, input bit perturb);
      int  waited;
      bit  seen;
      if (id) begin a1 = a; b1 = b; req1 = 1'b1; end
      else    begin a0 = a; b0 = b; req0 = 1'b1; end
      wait_gnt(id, waited, seen);
      req0 = 1'b0;
      req1 = 1'b0;
      check("grant_latency", waited, 1);
      if (!seen) return;
      check("other_gnt", {31'd0, id ? gnt0 : gnt1}, 0);
      check("busy_add", {31'd0, busy}, 1);
      if (perturb) begin
         a0 = W'($urandom); b0 = W'($urandom);
         a1 = W'($urandom); b1 = W'($urandom);
      end
      for (int k = 1; k <= W; k++) begin
         @(negedge clk);
         if (k == W - 1) begin
            check("done_early", {31'd0, done}, 0);
            check("out_hold", {24'd0, out}, {24'd0, prev_out});
            check("cout_hold", {31'd0, cout}, {31'd0, prev_cout});
         end
      end
      check("done", {31'd0, done}, 1);
      check("out", {24'd0, out}, {24'd0, eo});
      check("cout", {31'd0, cout}, {31'd0, ec});
      check("done_id", {31'd0, done_id}, {31'd0, id});
      $display("op id=%0d a=%0d b=%0d out=%0d cout=%0d exp_out=%0d exp_cout=%0d",
               id, a, b, out, cout, eo, ec);
      prev_out = eo;
      prev_cout = ec;
      @(negedge clk);
      check("done_clear", {31'd0, done}, 0);
      check("busy_idle", {31'd0, busy}, 0);
   endtask

   typedef struct {
      logic         id;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] exp_out;
      logic         exp_cout;
      bit           perturb;
   } vec_t;

   vec_t vecs[8];

   initial begin
      int       waited;
      bit       seen;
      int       d0, g1c, prev_g;
      logic     exp_last, exp_id;
      logic     rid;
      logic [W-1:0] ra, rb;
      logic [W:0]   s9;

      vecs[0] = '{1'b0, 8'd27,  8'd21,  8'd48,  1'b0, 1'b0};
      vecs[1] = '{1'b1, 8'd200, 8'd100, 8'd44,  1'b1, 1'b0};
      vecs[2] = '{1'b1, 8'd255, 8'd1,   8'd0,   1'b1, 1'b0};
      vecs[3] = '{1'b0, 8'd5,   8'd3,   8'd8,   1'b0, 1'b1};
      vecs[4] = '{1'b0, 8'd0,   8'd0,   8'd0,   1'b0, 1'b0};
      vecs[5] = '{1'b1, 8'd255, 8'd255, 8'd254, 1'b1, 1'b1};
      vecs[6] = '{1'b0, 8'd128, 8'd128, 8'd0,   1'b1, 1'b0};
      vecs[7] = '{1'b1, 8'd170, 8'd85,  8'd255, 1'b0, 1'b0};

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_gnt0", {31'd0, gnt0}, 0);
      check("rst_gnt1", {31'd0, gnt1}, 0);
      check("rst_busy", {31'd0, busy}, 0);
      check("rst_done", {31'd0, done}, 0);
      check("rst_done_id", {31'd0, done_id}, 0);
      check("rst_out", {24'd0, out}, 0);
      check("rst_cout", {31'd0, cout}, 0);
      reset = 1'b0;

      foreach (vecs[i])
         run_op(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].exp_out, vecs[i].exp_cout, vecs[i].perturb);

      // Request raised while busy and dropped before IDLE must be forgotten.
      a0 = 8'd1; b0 = 8'd2; req0 = 1'b1;
      wait_gnt(1'b0, waited, seen);
      req0 = 1'b0;
      check("ign_gnt0_seen", {31'd0, seen}, 1);
      d0 = done_count;
      g1c = gnt1_count;
      @(negedge clk);
      a1 = 8'd99; b1 = 8'd99; req1 = 1'b1;
      repeat (4) @(negedge clk);
      req1 = 1'b0;
      repeat (8) @(negedge clk);
      check("ign_no_gnt1", gnt1_count - g1c, 0);
      check("ign_one_done", done_count - d0, 1);
      check("ign_out", {24'd0, out}, 3);
      check("ign_done_id", {31'd0, done_id}, 0);
      $display("op id=0 a=1 b=2 out=%0d (req1 ignored while busy)", out);
      prev_out = 8'd3;
      prev_cout = 1'b0;

      // Reset in the 4th ADD cycle abandons the operation.
      a0 = 8'd7; b0 = 8'd9; req0 = 1'b1;
      wait_gnt(1'b0, waited, seen);
      req0 = 1'b0;
      check("rst_mid_gnt", {31'd0, seen}, 1);
      repeat (3) @(negedge clk);
      d0 = done_count;
      reset = 1'b1;
      #1;
      check("arst_busy", {31'd0, busy}, 0);
      check("arst_gnt", {30'd0, gnt1, gnt0}, 0);
      check("arst_done", {31'd0, done}, 0);
      check("arst_done_id", {31'd0, done_id}, 0);
      check("arst_out", {24'd0, out}, 0);
      check("arst_cout", {31'd0, cout}, 0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (12) @(negedge clk);
      check("arst_no_done", done_count - d0, 0);
      $display("op id=0 a=7 b=9 abandoned by reset");
      prev_out = '0;
      prev_cout = 1'b0;
      run_op(1'b0, 8'd5, 8'd3, 8'd8, 1'b0, 1'b0);

      // Both requests held from reset: grants alternate starting with requester 0.
      reset = 1'b1;
      a0 = 8'd10; b0 = 8'd20; a1 = 8'd30; b1 = 8'd40;
      req0 = 1'b1; req1 = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      exp_last = 1'b1;
      prev_g = -1;
      for (int n = 0; n < 4; n++) begin
         exp_id = ~exp_last;
         exp_last = exp_id;
         seen = 0;
         for (int t = 0; t < 20 && !seen; t++) begin
            @(negedge clk);
            if (gnt0 | gnt1) seen = 1;
         end
         check("rr_gnt_seen", {31'd0, seen}, 1);
         check("rr_gnt_id", {31'd0, gnt1}, {31'd0, exp_id});
         if (prev_g >= 0) check("rr_spacing", cyc - prev_g, W + 2);
         prev_g = cyc;
         repeat (W) @(negedge clk);
         if (n == 3) begin req0 = 1'b0; req1 = 1'b0; end
         check("rr_done", {31'd0, done}, 1);
         check("rr_done_id", {31'd0, done_id}, {31'd0, exp_id});
         check("rr_out", {24'd0, out}, exp_id ? 32'd70 : 32'd30);
         $display("op rr n=%0d id=%0d out=%0d", n, done_id, out);
      end
      @(negedge clk);
      prev_out = 8'd70;
      prev_cout = 1'b0;

      // Random operations against plain integer addition.
      for (int i = 0; i < 24; i++) begin
         rid = 1'($urandom_range(0, 1));
         ra = W'($urandom);
         rb = W'($urandom);
         s9 = {1'b0, ra} + {1'b0, rb};
         run_op(rid, ra, rb, s9[W-1:0], s9[W], 1'($urandom_range(0, 1)));
      end

      repeat (3) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
